// File: rtl/ising_ctrl_pkg.sv
// Shared definitions for the Ising core control front-end: register map,
// bit positions, sequencer states and register-bus request/response types.
package ising_ctrl_pkg;

    localparam int unsigned FLIP_ICON_DEPTH = 16;

    // Per-core register window size in bytes (five 32-bit registers)
    localparam int unsigned IC_NUM_REGS = 32'h14;

    localparam logic [5:0] OFS_CTRL      = 6'h00;
    localparam logic [5:0] OFS_STATUS    = 6'h04;
    localparam logic [5:0] OFS_NUM_ITER  = 6'h08;
    localparam logic [5:0] OFS_ITER_CNT  = 6'h0C;
    localparam logic [5:0] OFS_FLIP_BASE = 6'h10;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_ABORT   = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } ising_ctrl_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } lagd_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } lagd_reg_rsp_t;

endpackage

// File: rtl/ising_ctrl_regfile.sv
// Register file for one Ising core: address decode, byte strobes, pulse and
// write-1-to-clear bits, read mux and the single-cycle registered response.
module ising_ctrl_regfile
    import ising_ctrl_pkg::*;
#(
    parameter type         reg_req_t = lagd_reg_req_t,
    parameter type         reg_rsp_t = lagd_reg_rsp_t,
    parameter int unsigned IdxW      = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  reg_req_t        i_req,
    output reg_rsp_t        o_rsp,
    input  logic            i_busy,
    input  logic [15:0]     i_iter_cnt,
    input  logic            i_set_done,
    input  logic            i_set_aborted,
    input  logic            i_clr_flags,
    output logic [15:0]     o_num_iter,
    output logic [IdxW-1:0] o_flip_base,
    output logic            o_irq_en,
    output logic            o_done,
    output logic            o_aborted,
    output logic            o_start,
    output logic            o_abort
);

    reg_rsp_t        r_rsp;
    logic            r_irq_en;
    logic            r_done;
    logic            r_aborted;
    logic [15:0]     r_num_iter;
    logic [IdxW-1:0] r_flip_base;

    logic [5:0]  w_addr;
    logic        w_accept;
    logic        w_wr;
    logic        w_hit_ctrl, w_hit_stat, w_hit_num, w_hit_cnt, w_hit_flip;
    logic        w_err;
    logic        w_clr_done, w_clr_aborted;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A request is taken only when no response is pending, so a valid held
    // through its ready pulse is not accepted twice.
    assign w_accept   = i_req.valid && !r_rsp.ready;
    assign w_addr     = i_req.addr[5:0];
    assign w_hit_ctrl = (w_addr == OFS_CTRL);
    assign w_hit_stat = (w_addr == OFS_STATUS);
    assign w_hit_num  = (w_addr == OFS_NUM_ITER);
    assign w_hit_cnt  = (w_addr == OFS_ITER_CNT);
    assign w_hit_flip = (w_addr == OFS_FLIP_BASE);
    assign w_err      = !(w_hit_ctrl || w_hit_stat || w_hit_num || w_hit_cnt || w_hit_flip);
    assign w_wr       = w_accept && i_req.write;

    assign o_start       = w_wr && w_hit_ctrl && i_req.wstrb[0] && i_req.wdata[CTRL_START];
    assign o_abort       = w_wr && w_hit_ctrl && i_req.wstrb[0] && i_req.wdata[CTRL_ABORT];
    assign w_clr_done    = w_wr && w_hit_stat && i_req.wstrb[0] && i_req.wdata[STAT_DONE];
    assign w_clr_aborted = w_wr && w_hit_stat && i_req.wstrb[0] && i_req.wdata[STAT_ABORTED];

    assign w_unused = ^{i_req.addr, i_req.wdata, i_req.wstrb};

    // Read mux; pulse bits always read back as zero
    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl) begin
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
        end else if (w_hit_stat) begin
            w_rdata[STAT_BUSY]    = i_busy;
            w_rdata[STAT_DONE]    = r_done;
            w_rdata[STAT_ABORTED] = r_aborted;
        end else if (w_hit_num) begin
            w_rdata[15:0] = r_num_iter;
        end else if (w_hit_cnt) begin
            w_rdata[15:0] = i_iter_cnt;
        end else if (w_hit_flip) begin
            w_rdata[IdxW-1:0] = r_flip_base;
        end
    end

    // Registered response, one cycle after the request is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp <= '0;
        end else begin
            r_rsp <= '0;
            if (w_accept) begin
                r_rsp.ready <= 1'b1;
                r_rsp.error <= w_err;
                r_rsp.rdata <= i_req.write ? 32'd0 : w_rdata;
            end
        end
    end

    // Configuration fields; run parameters are frozen while a run is active
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq_en    <= 1'b0;
            r_num_iter  <= '0;
            r_flip_base <= '0;
        end else if (w_wr) begin
            if (w_hit_ctrl && i_req.wstrb[0]) r_irq_en <= i_req.wdata[CTRL_IRQ_EN];
            if (w_hit_num && !i_busy) begin
                if (i_req.wstrb[0]) r_num_iter[7:0]  <= i_req.wdata[7:0];
                if (i_req.wstrb[1]) r_num_iter[15:8] <= i_req.wdata[15:8];
            end
            if (w_hit_flip && !i_busy && i_req.wstrb[0]) r_flip_base <= i_req.wdata[IdxW-1:0];
        end
    end

    // Status flags: hardware set beats both run-start clear and software clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (i_set_done)                      r_done <= 1'b1;
            else if (i_clr_flags || w_clr_done)  r_done <= 1'b0;
            if (i_set_aborted)                      r_aborted <= 1'b1;
            else if (i_clr_flags || w_clr_aborted)  r_aborted <= 1'b0;
        end
    end

    assign o_rsp       = r_rsp;
    assign o_num_iter  = r_num_iter;
    assign o_flip_base = r_flip_base;
    assign o_irq_en    = r_irq_en;
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;

endmodule

// File: rtl/ising_core_ctrl.sv
// Control front-end for one Ising core: register window plus the sequencer
// that issues annealing steps through a req/ack handshake.
module ising_core_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter type         reg_req_t     = lagd_reg_req_t,
    parameter type         reg_rsp_t     = lagd_reg_rsp_t,
    parameter int unsigned FlipIconDepth = FLIP_ICON_DEPTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  reg_req_t                         reg_req_i,
    output reg_rsp_t                         reg_rsp_o,
    output logic                             step_req_o,
    input  logic                             step_ack_i,
    output logic [$clog2(FlipIconDepth)-1:0] flip_idx_o,
    output logic                             busy_o,
    output logic                             irq_o
);

    localparam int unsigned IdxW = $clog2(FlipIconDepth);

    ising_ctrl_state_e r_state;
    logic              r_step_req;
    logic              r_busy;
    logic [15:0]       r_iter_cnt;
    logic [IdxW-1:0]   r_flip;

    logic [15:0]       w_num_iter;
    logic [IdxW-1:0]   w_flip_base;
    logic              w_irq_en, w_done, w_aborted;
    logic              w_start, w_abort;
    logic              w_go, w_ack;
    logic              w_set_done, w_set_aborted;
    logic [15:0]       w_cnt_nxt;
    logic [IdxW-1:0]   w_flip_nxt;

    ising_ctrl_regfile #(
        .reg_req_t (reg_req_t),
        .reg_rsp_t (reg_rsp_t),
        .IdxW      (IdxW)
    ) u_regfile (
        .i_clk         (clk_i),
        .i_rst         (rst_i),
        .i_req         (reg_req_i),
        .o_rsp         (reg_rsp_o),
        .i_busy        (r_busy),
        .i_iter_cnt    (r_iter_cnt),
        .i_set_done    (w_set_done),
        .i_set_aborted (w_set_aborted),
        .i_clr_flags   (w_go),
        .o_num_iter    (w_num_iter),
        .o_flip_base   (w_flip_base),
        .o_irq_en      (w_irq_en),
        .o_done        (w_done),
        .o_aborted     (w_aborted),
        .o_start       (w_start),
        .o_abort       (w_abort)
    );

    // ABORT in the same write suppresses START
    assign w_go       = (r_state == ST_IDLE) && w_start && !w_abort;
    assign w_ack      = (r_state == ST_REQ) && step_ack_i;
    assign w_cnt_nxt  = r_iter_cnt + 16'd1;
    assign w_flip_nxt = (r_flip == IdxW'(FlipIconDepth - 1)) ? '0 : r_flip + IdxW'(1);

    // DONE is raised on the edge that enters the DONE state so irq_o rises with it
    assign w_set_done    = (w_go && (w_num_iter == 16'd0)) ||
                           (w_ack && !w_abort && (w_cnt_nxt == w_num_iter));
    assign w_set_aborted = w_abort && ((r_state == ST_REQ) || (r_state == ST_WAIT));

    // Step sequencer; an ack coinciding with an abort is still counted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_step_req <= 1'b0;
            r_busy     <= 1'b0;
            r_iter_cnt <= '0;
            r_flip     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_iter_cnt <= '0;
                        r_flip     <= w_flip_base;
                        r_busy     <= 1'b1;
                        if (w_num_iter == 16'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_REQ;
                            r_step_req <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (step_ack_i) begin
                        r_iter_cnt <= w_cnt_nxt;
                        r_flip     <= w_flip_nxt;
                        r_step_req <= 1'b0;
                        if (w_abort) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_cnt_nxt == w_num_iter) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_abort) begin
                        r_state    <= ST_IDLE;
                        r_step_req <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= ST_REQ;
                        r_step_req <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign step_req_o = r_step_req;
    assign busy_o     = r_busy;
    assign flip_idx_o = r_flip;
    assign irq_o      = w_done && w_irq_en;

endmodule

// File: tb/tb_ising_core_ctrl.sv
// Scoreboard bench for ising_core_ctrl: bus responses are checked by a
// monitor against a queue of expected values pushed by the stimulus.
module tb_ising_core_ctrl;
    import ising_ctrl_pkg::*;

    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    lagd_reg_req_t req;
    lagd_reg_rsp_t rsp;
    logic          step_req;
    logic          step_ack = 1'b0;
    logic [3:0]    flip;
    logic          busy;
    logic          irq;

    ising_core_ctrl #(.FlipIconDepth(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .reg_req_i  (req),
        .reg_rsp_o  (rsp),
        .step_req_o (step_req),
        .step_ack_i (step_ack),
        .flip_idx_o (flip),
        .busy_o     (busy),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (rsp.ready === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp: got ready with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_err"}, 32'(rsp.error), 32'(e.err));
                if (e.chk_data) chk({e.name, "_rdata"}, rsp.rdata, e.data);
            end
        end
    end

    // Ack responder: acks in the dly-th cycle of each request and logs flip indices
    int         dly = 1;
    int         ack_cnt = 0;
    int         req_cycles = 0;
    int         n_steps = 0;
    int         flips[$];
    logic [3:0] flip_lat = '0;

    always @(negedge clk) begin
        if (rst) begin
            step_ack = 1'b0;
            ack_cnt  = 0;
        end else if (step_req) begin
            if (ack_cnt == 0) flip_lat = flip;
            else chk("flip_stable", 32'(flip), 32'(flip_lat));
            req_cycles++;
            step_ack = (ack_cnt == dly - 1);
            if (step_ack) begin
                flips.push_back(int'(flip));
                n_steps++;
            end
            ack_cnt++;
        end else begin
            step_ack = 1'b0;
            ack_cnt  = 0;
        end
    end

    task automatic bus(input logic [5:0] a, input bit wr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_d, input bit exp_e,
                       input string name);
        exp_t e;
        e.data = exp_d; e.err = exp_e; e.chk_data = !wr; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        req.addr  = {26'd0, a};
        req.write = wr;
        req.wdata = wd;
        req.wstrb = ws;
        req.valid = 1'b1;
        @(negedge clk);
        req.valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp_d, input string name);
        bus(a, 1'b0, 32'd0, 4'h0, exp_d, 1'b0, name);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] ws);
        bus(a, 1'b1, d, ws, 32'd0, 1'b0, "wr");
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: busy_o=1, expected 0", name);
        end
    endtask

    // ev packs expected flip indices, first step in the low byte
    task automatic chk_flips(input string name, input int n, input logic [31:0] ev);
        chk({name, "_nsteps"}, 32'(flips.size()), 32'(n));
        for (int i = 0; i < n && i < flips.size(); i++)
            chk({name, "_flip"}, 32'(flips[i]), 32'(ev[8*i +: 8]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rsp.rdata, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp.error, rsp.ready}, 32'd0);
        chk("rst_outputs", {25'd0, step_req, busy, irq, flip}, 32'd0);
        rst = 1'b0;

        // Reset values and bad offset
        bus(6'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, "wr_bad");
        rd(6'h00, 32'd0, "rd_ctrl0");
        rd(6'h04, 32'd0, "rd_stat0");
        rd(6'h08, 32'd0, "rd_num0");
        rd(6'h0C, 32'd0, "rd_cnt0");
        rd(6'h10, 32'd0, "rd_flip0");
        bus(6'h14, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, "rd_bad");

        // Basic run, ack in the request cycle, flip index wraps
        wr(6'h10, 32'd14, 4'hF);
        wr(6'h08, 32'd3, 4'hF);
        rd(6'h10, 32'd14, "rd_flipbase");
        rd(6'h08, 32'd3, "rd_num3");
        flips.delete(); n_steps = 0; dly = 1;
        wr(6'h00, 32'h1, 4'hF);
        chk("start_busy_req", {30'd0, busy, step_req}, 32'h3);
        wait_idle("run1");
        chk_flips("run1", 3, {8'd0, 8'd0, 8'd15, 8'd14});
        rd(6'h0C, 32'd3, "run1_cnt");
        rd(6'h04, 32'h2, "run1_status");
        chk("run1_irq_off", 32'(irq), 32'd0);
        wr(6'h00, 32'h4, 4'hF);
        chk("irq_en_on", 32'(irq), 32'd1);
        rd(6'h00, 32'h4, "rd_ctrl_irqen");
        wr(6'h04, 32'h2, 4'hF);
        chk("irq_w1c", 32'(irq), 32'd0);
        rd(6'h04, 32'h0, "status_cleared");

        // Delayed ack; NUM_ITER write mid-run must be ignored
        wr(6'h10, 32'd3, 4'hF);
        wr(6'h08, 32'd2, 4'hF);
        flips.delete(); req_cycles = 0; dly = 5;
        wr(6'h00, 32'h5, 4'hF);
        wr(6'h08, 32'd7, 4'hF);
        wait_idle("run2");
        chk_flips("run2", 2, {8'd0, 8'd0, 8'd4, 8'd3});
        chk("run2_req_cycles", 32'(req_cycles), 32'd10);
        rd(6'h08, 32'd2, "run2_num");
        rd(6'h0C, 32'd2, "run2_cnt");
        rd(6'h04, 32'h2, "run2_status");
        chk("run2_irq", 32'(irq), 32'd1);
        wr(6'h04, 32'h2, 4'hF);

        // Abort during the second WAIT
        wr(6'h08, 32'd10, 4'hF);
        wr(6'h10, 32'd0, 4'hF);
        flips.delete(); n_steps = 0; dly = 1;
        wr(6'h00, 32'h1, 4'hF);
        k = 0;
        do begin @(posedge clk); #2; k++; end
        while (!(n_steps == 2 && !step_req && busy) && k < 100);
        wr(6'h00, 32'h2, 4'hF);
        chk("abort_wait_busy", {30'd0, busy, step_req}, 32'd0);
        rd(6'h0C, 32'd2, "abort_wait_cnt");
        rd(6'h04, 32'h4, "abort_wait_status");

        // Abort coinciding with an ack: that ack is counted
        flips.delete(); n_steps = 0; dly = 3;
        wr(6'h00, 32'h1, 4'hF);
        k = 0;
        do begin @(posedge clk); #2; k++; end
        while (!(n_steps == 1 && step_req && ack_cnt == 2) && k < 100);
        wr(6'h00, 32'h2, 4'hF);
        chk("abort_ack_busy", 32'(busy), 32'd0);
        chk("abort_ack_steps", 32'(n_steps), 32'd2);
        rd(6'h0C, 32'd2, "abort_ack_cnt");
        rd(6'h04, 32'h4, "abort_ack_status");

        // NUM_ITER=0: straight to DONE with no request
        wr(6'h08, 32'd0, 4'hF);
        n_steps = 0; dly = 1;
        wr(6'h00, 32'h1, 4'hF);
        repeat (3) @(negedge clk);
        chk("zero_iter_steps", 32'(n_steps), 32'd0);
        chk("zero_iter_busy", 32'(busy), 32'd0);
        rd(6'h04, 32'h2, "zero_iter_status");
        chk("zero_iter_irq", 32'(irq), 32'd0);

        // START and ABORT together: stays idle, flags untouched
        wr(6'h08, 32'd4, 4'hF);
        wr(6'h00, 32'h3, 4'hF);
        chk("start_abort_idle", {30'd0, busy, step_req}, 32'd0);
        rd(6'h04, 32'h2, "start_abort_status");
        wr(6'h04, 32'h2, 4'hF);
        rd(6'h04, 32'h0, "w1c_done");

        // Partial byte strobe on NUM_ITER
        wr(6'h08, 32'h0000_ABCD, 4'b0010);
        rd(6'h08, 32'h0000_AB04, "wstrb_num");

        // Asynchronous reset in the middle of a request
        wr(6'h08, 32'd5, 4'hF);
        dly = 8;
        wr(6'h00, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_rst_outs", {29'd0, step_req, busy, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(6'h08, 32'd0, "post_rst_num");
        wr(6'h08, 32'd2, 4'hF);
        wr(6'h10, 32'd15, 4'hF);
        flips.delete(); dly = 1;
        wr(6'h00, 32'h1, 4'hF);
        wait_idle("run_post_rst");
        chk_flips("run_post_rst", 2, {8'd0, 8'd0, 8'd0, 8'd15});
        rd(6'h04, 32'h2, "post_rst_status");
        rd(6'h0C, 32'd2, "post_rst_cnt");

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
